// File: rtl/exception_controller.sv
// rtl/exception_controller.sv - prioritising exception controller with pending latch, enable mask and ExcAck/ERet handshake
// Non-nesting: one exception is requested and serviced at a time, lowest index wins.
module exception_controller #(
    parameter int NSRC = 4,
    parameter int CW   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq_req,
    input  logic            ExcAck,
    input  logic            ERet,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    output logic            Exc,
    output logic [3:0]      EStatus,
    output logic [NSRC-1:0] pending,
    output logic            in_handler,
    output logic [CW-1:0]   exc_count,
    output logic            spurious_eret
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_SERVICE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] cand;
    logic [NSRC-1:0] clr;
    logic [3:0]      sel;
    logic [3:0]      cur_src;
    logic            start;
    logic            take;
    logic            finish;

    assign cand = pending & mask;

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        sel = 4'd0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel = 4'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            clr[i] = take && (cur_src == 4'(i));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Exc        = 1'b0;
        in_handler = 1'b0;
        start      = 1'b0;
        take       = 1'b0;
        finish     = 1'b0;
        case (state)
            S_IDLE: begin
                if (|cand) begin
                    start      = 1'b1;
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                Exc = 1'b1;
                if (ExcAck) begin
                    take       = 1'b1;
                    state_next = S_SERVICE;
                end
            end
            S_SERVICE: begin
                in_handler = 1'b1;
                if (ERet) begin
                    finish     = 1'b1;
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // New requests win over the clear of the source being acknowledged.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            mask    <= '1;
        end else begin
            pending <= (pending & ~clr) | irq_req;
            if (mask_we) begin
                mask <= mask_wdata;
            end
        end
    end

    // EStatus is latched on entry to REQ so later requests or mask writes cannot disturb it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            EStatus <= 4'd0;
            cur_src <= 4'd0;
        end else if (start) begin
            EStatus <= sel + 4'd1;
            cur_src <= sel;
        end else if (finish) begin
            EStatus <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_count     <= '0;
            spurious_eret <= 1'b0;
        end else begin
            if (take && (exc_count != {CW{1'b1}})) begin
                exc_count <= exc_count + 1'b1;
            end
            if (ERet && (state != S_SERVICE)) begin
                spurious_eret <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_exception_controller.sv
// tb/tb_exception_controller.sv - directed and random checks of exception_controller against a behavioural model
module tb_exception_controller;

    localparam int NSRC = 4;
    localparam int CW   = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NSRC-1:0] irq_req;
    logic            ExcAck;
    logic            ERet;
    logic            mask_we;
    logic [NSRC-1:0] mask_wdata;
    logic            Exc;
    logic [3:0]      EStatus;
    logic [NSRC-1:0] pending;
    logic            in_handler;
    logic [CW-1:0]   exc_count;
    logic            spurious_eret;

    int vectors     = 0;
    int miscompares = 0;

    // Model: the code being handled (0 = none), and whether it is still being requested or in service.
    logic [3:0] m_pending;
    logic [3:0] m_mask;
    int         m_code;
    bit         m_requesting;
    bit         m_servicing;
    int         m_count;
    bit         m_spur;

    exception_controller #(.NSRC(NSRC), .CW(CW)) dut (
        .clk          (clk),
        .reset        (reset),
        .irq_req      (irq_req),
        .ExcAck       (ExcAck),
        .ERet         (ERet),
        .mask_we      (mask_we),
        .mask_wdata   (mask_wdata),
        .Exc          (Exc),
        .EStatus      (EStatus),
        .pending      (pending),
        .in_handler   (in_handler),
        .exc_count    (exc_count),
        .spurious_eret(spurious_eret)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_pending    = 4'd0;
        m_mask       = 4'hf;
        m_code       = 0;
        m_requesting = 0;
        m_servicing  = 0;
        m_count      = 0;
        m_spur       = 0;
    endtask

    function automatic int lowest_set(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_step();
        logic [3:0] old_pending;
        logic [3:0] old_mask;
        logic [3:0] acked;
        bit         accepted;
        int         winner;
        if (!reset) begin
            model_reset();
            return;
        end
        old_pending = m_pending;
        old_mask    = m_mask;
        accepted    = m_requesting && ExcAck;
        acked       = accepted ? 4'(1 << (m_code - 1)) : 4'd0;
        m_pending   = (old_pending & ~acked) | irq_req;
        if (mask_we) m_mask = mask_wdata;
        if (ERet && !m_servicing) m_spur = 1;
        if (accepted && m_count < (1 << CW) - 1) m_count++;
        if (!m_requesting && !m_servicing) begin
            winner = lowest_set(old_pending & old_mask);
            if (winner >= 0) begin
                m_code       = winner + 1;
                m_requesting = 1;
            end
        end else if (m_requesting) begin
            if (accepted) begin
                m_requesting = 0;
                m_servicing  = 1;
            end
        end else if (ERet) begin
            m_servicing = 0;
            m_code      = 0;
        end
    endtask

    task automatic chk(input string tag, input int observed, input int expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic check_model();
        chk("Exc", int'(Exc), int'(m_requesting));
        chk("EStatus", int'(EStatus), m_code);
        chk("pending", int'(pending), int'(m_pending));
        chk("in_handler", int'(in_handler), int'(m_servicing));
        chk("exc_count", int'(exc_count), m_count);
        chk("spurious_eret", int'(spurious_eret), int'(m_spur));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic idle_inputs();
        irq_req    = '0;
        ExcAck     = 1'b0;
        ERet       = 1'b0;
        mask_we    = 1'b0;
        mask_wdata = '0;
    endtask

    task automatic take_one(input int src, input int expect_count);
        irq_req = 4'(1 << src);
        cycle();
        irq_req = '0;
        cycle();
        chk("take_exc", int'(Exc), 1);
        ExcAck = 1'b1;
        cycle();
        ExcAck = 1'b0;
        chk("take_count", int'(exc_count), expect_count);
        ERet = 1'b1;
        cycle();
        ERet = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) cycle();
        chk("rst_exc", int'(Exc), 0);
        chk("rst_estatus", int'(EStatus), 0);
        chk("rst_pending", int'(pending), 0);
        chk("rst_count", int'(exc_count), 0);
        reset = 1'b1;
        cycle();

        // Single request held unacknowledged.
        irq_req = 4'b0100;
        cycle();
        chk("t1_pending", int'(pending), 4'b0100);
        irq_req = '0;
        cycle();
        chk("t1_exc", int'(Exc), 1);
        chk("t1_estatus", int'(EStatus), 3);
        repeat (5) cycle();
        chk("t1_hold_exc", int'(Exc), 1);
        chk("t1_hold_estatus", int'(EStatus), 3);
        ExcAck = 1'b1;
        cycle();
        ExcAck = 1'b0;
        ERet   = 1'b1;
        cycle();
        ERet   = 1'b0;

        // Priority between two pending sources.
        irq_req = 4'b1010;
        cycle();
        irq_req = '0;
        cycle();
        chk("t2_estatus", int'(EStatus), 2);
        ExcAck = 1'b1;
        cycle();
        ExcAck = 1'b0;
        chk("t2_pending", int'(pending), 4'b1000);
        chk("t2_in_handler", int'(in_handler), 1);
        ERet = 1'b1;
        cycle();
        ERet = 1'b0;
        cycle();
        chk("t2_exc", int'(Exc), 1);
        chk("t2_estatus2", int'(EStatus), 4);
        ExcAck = 1'b1;
        cycle();
        ExcAck = 1'b0;
        ERet   = 1'b1;
        cycle();
        ERet   = 1'b0;

        // Masked source pends but is not taken until enabled.
        mask_we    = 1'b1;
        mask_wdata = 4'b1110;
        irq_req    = 4'b0001;
        cycle();
        mask_we = 1'b0;
        irq_req = '0;
        chk("t3_pending", int'(pending), 4'b0001);
        repeat (2) cycle();
        chk("t3_masked_exc", int'(Exc), 0);
        mask_we    = 1'b1;
        mask_wdata = 4'b1111;
        cycle();
        mask_we = 1'b0;
        cycle();
        chk("t3_exc", int'(Exc), 1);
        chk("t3_estatus", int'(EStatus), 1);

        // Re-request of source 0 on the acknowledge cycle survives the clear.
        ExcAck  = 1'b1;
        irq_req = 4'b0001;
        cycle();
        ExcAck  = 1'b0;
        irq_req = '0;
        chk("t4_pending", int'(pending), 4'b0001);
        ERet = 1'b1;
        cycle();
        ERet = 1'b0;
        cycle();
        chk("t4_exc", int'(Exc), 1);
        chk("t4_estatus", int'(EStatus), 1);
        ExcAck = 1'b1;
        cycle();
        ExcAck = 1'b0;
        ERet   = 1'b1;
        cycle();
        ERet   = 1'b0;

        // Stray ERet and ExcAck while idle.
        ERet = 1'b1;
        cycle();
        ERet = 1'b0;
        chk("t5_spurious", int'(spurious_eret), 1);
        ExcAck = 1'b1;
        cycle();
        ExcAck = 1'b0;
        chk("t5_spurious_sticky", int'(spurious_eret), 1);
        chk("t5_in_handler", int'(in_handler), 0);

        // Counter saturation from a fresh reset.
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        take_one(1, 1);
        take_one(2, 2);
        take_one(0, 3);
        take_one(3, 3);
        take_one(1, 3);

        // Asynchronous reset while requesting.
        irq_req = 4'b0010;
        cycle();
        irq_req = '0;
        cycle();
        chk("t6_pre_exc", int'(Exc), 1);
        reset = 1'b0;
        #1;
        model_reset();
        chk("t6_async_exc", int'(Exc), 0);
        chk("t6_async_estatus", int'(EStatus), 0);
        chk("t6_async_pending", int'(pending), 0);
        chk("t6_async_count", int'(exc_count), 0);
        cycle();
        reset = 1'b1;
        cycle();

        // Random traffic.
        for (int n = 0; n < 600; n++) begin
            irq_req    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'd0;
            ExcAck     = ($urandom_range(0, 2) == 0);
            ERet       = ($urandom_range(0, 3) == 0);
            mask_we    = ($urandom_range(0, 7) == 0);
            mask_wdata = 4'($urandom);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
